sram_controller: RTL and testbench



---
 rtl/sram_controller_pkg.sv | 24 ++
 rtl/sram_controller.sv | 139 +++++++++++++
 tb/tb_sram_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared widths and FSM state encodings for the MEM-stage SRAM controller.
// Also provides the CPU byte address to SRAM word mapping.
package sram_controller_pkg;

  localparam int ADDRESS_LEN   = 32;
  localparam int SRAM_ADDR_LEN = 18;
  localparam int SRAM_DATA_LEN = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // 32-bit word index relative to base; the two half-words occupy SRAM words 2n and 2n+1
  function automatic logic [SRAM_ADDR_LEN-2:0] sram_word(
    input logic [ADDRESS_LEN-1:0] addr,
    input logic [ADDRESS_LEN-1:0] base
  );
    logic [ADDRESS_LEN-1:0] diff;
    diff = addr - base;
    return diff[SRAM_ADDR_LEN:2];
  endfunction

endpackage

// File: rtl/sram_controller.sv
// MEM-stage responder: one 32-bit read/write per request, performed as two
// 16-bit transfers (low half, then high half) on an asynchronous SRAM.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int                     WAIT_CYCLES = 2,
  parameter logic [ADDRESS_LEN-1:0] BASE_ADDR   = 32'd1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic [ADDRESS_LEN-1:0]   address,
  input  logic [31:0]              wr_data,
  output logic [31:0]              rd_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  logic [1:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     op_wr_q, op_wr_d;
  logic [SRAM_ADDR_LEN-2:0] word_q, word_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [SRAM_DATA_LEN-1:0] rd_lo_q, rd_lo_d;
  logic [31:0]              rd_data_q, rd_data_d;
  logic [SRAM_ADDR_LEN-1:0] sram_addr_q, sram_addr_d;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out_q, sram_dq_out_d;
  logic                     sram_dq_oe_q, sram_dq_oe_d;
  logic                     sram_we_n_q, sram_we_n_d;
  logic                     req;
  logic                     last;
  logic [SRAM_ADDR_LEN-2:0] req_word;

  assign req      = rd_en | wr_en;
  assign last     = (cnt_q == CNT_LAST);
  assign req_word = sram_word(address, BASE_ADDR);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_wr_d       = op_wr_q;
    word_d        = word_q;
    wdata_d       = wdata_q;
    rd_lo_d       = rd_lo_q;
    rd_data_d     = rd_data_q;
    sram_addr_d   = sram_addr_q;
    sram_dq_out_d = sram_dq_out_q;
    sram_dq_oe_d  = sram_dq_oe_q;
    sram_we_n_d   = sram_we_n_q;
    ready         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = ~req;
        if (req) begin
          // SRAM outputs are registered, so the low-half bus values are loaded on entry to LOW
          state_d       = ST_LOW;
          cnt_d         = '0;
          op_wr_d       = wr_en;
          word_d        = req_word;
          wdata_d       = wr_data;
          sram_addr_d   = {req_word, 1'b0};
          sram_dq_out_d = wr_data[15:0];
          sram_dq_oe_d  = wr_en;
          sram_we_n_d   = ~wr_en;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d       = ST_HIGH;
          cnt_d         = '0;
          rd_lo_d       = sram_dq_in;
          sram_addr_d   = {word_q, 1'b1};
          sram_dq_out_d = wdata_q[31:16];
        end
      end
      ST_HIGH: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d      = ST_DONE;
          cnt_d        = '0;
          sram_dq_oe_d = 1'b0;
          sram_we_n_d  = 1'b1;
          // Low half is staged so rd_data only changes when a read completes
          if (!op_wr_q) rd_data_d = {sram_dq_in, rd_lo_q};
        end
      end
      ST_DONE: begin
        ready   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_wr_q       <= 1'b0;
      word_q        <= '0;
      wdata_q       <= '0;
      rd_lo_q       <= '0;
      rd_data_q     <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_wr_q       <= op_wr_d;
      word_q        <= word_d;
      wdata_q       <= wdata_d;
      rd_lo_q       <= rd_lo_d;
      rd_data_q     <= rd_data_d;
      sram_addr_q   <= sram_addr_d;
      sram_dq_out_q <= sram_dq_out_d;
      sram_dq_oe_q  <= sram_dq_oe_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES 2 and 1) on behavioural SRAMs,
// checked every cycle against an access-timeline model plus directed literal checks.
module tb_sram_controller;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_i [2];
  logic        wr_i [2];
  logic [31:0] ad_i [2];
  logic [31:0] wd_i [2];
  logic [31:0] rdd  [2];
  logic        rdy  [2];
  logic [17:0] sa   [2];
  logic [15:0] dqo  [2];
  logic [15:0] dqi  [2];
  logic        oe   [2];
  logic        wen  [2];

  logic [15:0] mem [2][256];
  logic [15:0] em  [2][256];
  bit          mem_init = 1'b0;
  bit          em_init  = 1'b0;

  int          errors = 0;
  int          checks = 0;

  int unsigned mk      [2] = '{0, 0};
  logic        mop     [2];
  logic [16:0] mw      [2];
  logic [31:0] md      [2];
  logic [31:0] rhold   [2];
  bit          started [2] = '{1'b0, 1'b0};
  bit          post    [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  sram_controller #(.WAIT_CYCLES(2), .BASE_ADDR(32'd1024)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_i[0]), .rd_en(rd_i[0]), .address(ad_i[0]),
    .wr_data(wd_i[0]), .rd_data(rdd[0]), .ready(rdy[0]), .sram_addr(sa[0]),
    .sram_dq_out(dqo[0]), .sram_dq_in(dqi[0]), .sram_dq_oe(oe[0]), .sram_we_n(wen[0])
  );

  sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_i[1]), .rd_en(rd_i[1]), .address(ad_i[1]),
    .wr_data(wd_i[1]), .rd_data(rdd[1]), .ready(rdy[1]), .sram_addr(sa[1]),
    .sram_dq_out(dqo[1]), .sram_dq_in(dqi[1]), .sram_dq_oe(oe[1]), .sram_we_n(wen[1])
  );

  function automatic logic [15:0] pat(input int i, input int j);
    return 16'((j * 40503 + i * 7919 + 4951) & 16'hFFFF);
  endfunction

  // Behavioural SRAMs: combinational read, write while we_n is low
  assign dqi[0] = mem[0][sa[0][7:0]];
  assign dqi[1] = mem[1][sa[1][7:0]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 256; j++) mem[i][j] <= pat(i, j);
      mem_init <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++)
        if (wen[i] === 1'b0) mem[i][sa[i][7:0]] <= dqo[i];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Timeline model: cycle k of an access (k=1..2W transfers, k=2W+1 done)
  always @(negedge clk) begin : model
    int unsigned w;
    int unsigned k;
    logic        hi;
    logic        ex_rdy, ex_wen, ex_oe, ck_a, ck_d;
    logic [17:0] ex_a;
    logic [15:0] ex_d;
    if (!em_init) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 256; j++) em[i][j] = pat(i, j);
      em_init = 1'b1;
    end
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? 2 : 1;
      k = mk[i];
      if (started[i]) begin
        ex_rdy = (k == 0) ? !(rd_i[i] | wr_i[i]) : (k == 2 * w + 1);
        ex_wen = 1'b1;
        ex_oe  = 1'b0;
        ck_a   = post[i];
        ck_d   = post[i];
        ex_a   = '0;
        ex_d   = '0;
        if (k >= 1 && k <= 2 * w) begin
          hi   = (k > w);
          ex_a = {mw[i], hi};
          ck_a = 1'b1;
          if (mop[i]) begin
            ex_wen = 1'b0;
            ex_oe  = 1'b1;
            ex_d   = hi ? md[i][31:16] : md[i][15:0];
            ck_d   = 1'b1;
            em[i][ex_a[7:0]] = ex_d;
          end
        end
        chk($sformatf("u%0d ready k=%0d", i, k), rdy[i], ex_rdy);
        chk($sformatf("u%0d we_n k=%0d", i, k), wen[i], ex_wen);
        chk($sformatf("u%0d oe k=%0d", i, k), oe[i], ex_oe);
        chk($sformatf("u%0d rd_data k=%0d", i, k), rdd[i], rhold[i]);
        if (ck_a) chk($sformatf("u%0d sram_addr k=%0d", i, k), sa[i], ex_a);
        if (ck_d) chk($sformatf("u%0d dq_out k=%0d", i, k), dqo[i], ex_d);
      end
      if (rst) begin
        mk[i]      = 0;
        rhold[i]   = '0;
        started[i] = 1'b1;
        post[i]    = 1'b1;
      end else if (k == 0) begin
        if (rd_i[i] | wr_i[i]) begin
          mk[i]   = 1;
          mop[i]  = wr_i[i];
          mw[i]   = 17'((ad_i[i] - BASE) >> 2);
          md[i]   = wd_i[i];
          post[i] = 1'b0;
        end
      end else if (k == 2 * w + 1) begin
        mk[i] = 0;
      end else begin
        if (k == 2 * w && !mop[i])
          rhold[i] = {em[i][{mw[i][6:0], 1'b1}], em[i][{mw[i][6:0], 1'b0}]};
        mk[i] = k + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    rd_i[i] = r;
    wr_i[i] = w;
    ad_i[i] = a;
    wd_i[i] = d;
  endtask

  logic [7:0]  rpat;
  logic [17:0] apat [8];

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) req(i, 1'b0, 1'b0, BASE, '0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset ready", rdy[0], 1'b1);
    chk("reset we_n", wen[0], 1'b1);
    chk("reset oe", oe[0], 1'b0);
    chk("reset rd_data", rdd[0], 32'h0);
    chk("reset sram_addr", sa[0], 18'h0);

    // Write 0xDEADBEEF to 1028
    tick(); req(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF); #1;
    chk("wr c0 ready", rdy[0], 1'b0);
    tick(); req(0, 1'b0, 1'b0, 32'd1028, 32'hDEADBEEF); #1;
    chk("wr c1 addr", sa[0], 18'd2);
    chk("wr c1 dq", dqo[0], 16'hBEEF);
    chk("wr c1 we_n", wen[0], 1'b0);
    tick(); tick(); #1;
    chk("wr c3 addr", sa[0], 18'd3);
    chk("wr c3 dq", dqo[0], 16'hDEAD);
    tick(); #1;
    chk("wr c4 ready", rdy[0], 1'b0);
    tick(); #1;
    chk("wr c5 ready", rdy[0], 1'b1);
    chk("wr c5 we_n", wen[0], 1'b1);

    // Read it back
    tick(); req(0, 1'b1, 1'b0, 32'd1028, '0);
    tick(); req(0, 1'b0, 1'b0, 32'd1028, '0);
    tick(); tick(); tick();
    tick(); #1;
    chk("rd c5 ready", rdy[0], 1'b1);
    chk("rd c5 rd_data", rdd[0], 32'hDEADBEEF);

    // Simultaneous rd_en and wr_en: write wins
    tick(); req(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
    tick(); req(0, 1'b0, 1'b0, 32'd1024, '0);
    repeat (5) tick();
    chk("both word0", mem[0][0], 16'h5678);
    chk("both word1", mem[0][1], 16'h1234);

    // Reset during cycle 3 of a write, then a fresh access
    tick(); req(0, 1'b0, 1'b1, 32'd1040, 32'hA5A55A5A);
    tick(); req(0, 1'b0, 1'b0, 32'd1040, '0);
    tick();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rst we_n", wen[0], 1'b1);
    chk("rst oe", oe[0], 1'b0);
    chk("rst ready", rdy[0], 1'b1);
    tick(); req(0, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
    tick(); req(0, 1'b0, 1'b0, 32'd1040, '0);
    repeat (5) tick();
    req(0, 1'b1, 1'b0, 32'd1042, '0);
    tick(); req(0, 1'b0, 1'b0, 32'd1040, '0);
    repeat (4) tick();
    #1;
    chk("fresh rd_data", rdd[0], 32'hCAFEF00D);

    // WAIT_CYCLES=1: back-to-back reads with the request held; address advances in DONE
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c == 0) req(1, 1'b1, 1'b0, 32'd1024, '0);
      if (c == 3) ad_i[1] = 32'd1032;
      #1;
      rpat[c] = rdy[1];
      apat[c] = sa[1];
    end
    tick(); req(1, 1'b0, 1'b0, BASE, '0);
    chk("w1 ready pattern", rpat, 8'b1000_1000);
    chk("w1 addr c1", apat[1], 18'd0);
    chk("w1 addr c2", apat[2], 18'd1);
    chk("w1 addr c5", apat[5], 18'd4);
    chk("w1 addr c6", apat[6], 18'd5);

    // Randomized traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          rd_i[i] = ($urandom_range(0, 2) == 0);
          wr_i[i] = ($urandom_range(0, 2) == 0);
          wd_i[i] = $urandom;
          if ($urandom_range(0, 15) == 0) ad_i[i] = $urandom;
          else ad_i[i] = BASE + ($urandom_range(0, 60) << 2) + $urandom_range(0, 3);
        end
      end
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) req(i, 1'b0, 1'b0, BASE, '0);
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
